// File: rtl/bypass_rr_arbiter.sv
// Round-robin front end for the Bypass datapath: NUM_REQ valid/ready requesters
// share one registered output word; Output_Data feeds Bypass.Input_Data.

module bypass_rr_lane #(
  parameter int IDX        = 0,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ID_WIDTH-1:0]   last_grant,
  input  logic                  grant,
  output logic                  hi,
  output logic [DATA_WIDTH-1:0] data_g
);
  localparam logic [ID_WIDTH-1:0] IDX_L = ID_WIDTH'(IDX);

  // hi marks requests that sit after the pointer and so win ahead of the wrap
  assign hi     = valid & (IDX_L > last_grant);
  assign data_g = data & {DATA_WIDTH{grant}};
endmodule

module bypass_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ready,
  output logic [DATA_WIDTH-1:0]         Output_Data,
  output logic                          Output_Valid,
  input  logic                          Output_Ready,
  output logic [ID_WIDTH-1:0]           Grant_Id
);
  typedef struct packed {
    logic                any;
    logic [ID_WIDTH-1:0] id;
    logic [NUM_REQ-1:0]  oh;
  } win_t;

  logic [ID_WIDTH-1:0]                  last_grant;
  logic [NUM_REQ-1:0]                   hi;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   lane_data;
  logic [DATA_WIDTH-1:0]                mux_data;
  win_t                                 win;
  logic                                 found_hi;
  logic                                 load;
  logic                                 xfer;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    bypass_rr_lane #(
      .IDX(i), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) u_lane (
      .valid      (Req_Valid[i]),
      .data       (Req_Data[i*DATA_WIDTH +: DATA_WIDTH]),
      .last_grant (last_grant),
      .grant      (win.oh[i]),
      .hi         (hi[i]),
      .data_g     (lane_data[i])
    );
  end

  // Lowest index above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    win      = '0;
    found_hi = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (Req_Valid[i] && !win.any) begin
        win.any = 1'b1;
        win.id  = ID_WIDTH'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (hi[i] && !found_hi) begin
        found_hi = 1'b1;
        win.id   = ID_WIDTH'(i);
      end
    win.oh = win.any ? (NUM_REQ'(1) << win.id) : '0;
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) mux_data = mux_data | lane_data[i];
  end

  assign load      = !Output_Valid | Output_Ready;
  // rst_n gate keeps every requester stalled while reset is held
  assign Req_Ready = win.oh & {NUM_REQ{load & rst_n}};
  assign xfer      = |Req_Ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output_Valid <= 1'b0;
      Output_Data  <= '0;
      Grant_Id     <= '0;
      last_grant   <= ID_WIDTH'(NUM_REQ-1);
    end else if (xfer) begin
      Output_Valid <= 1'b1;
      Output_Data  <= mux_data;
      Grant_Id     <= win.id;
      last_grant   <= win.id;
    end else if (Output_Ready) begin
      Output_Valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bypass_rr_arbiter.sv
// Directed vector table plus randomized traffic against a modular-search model.

module tb_bypass_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   Req_Valid = '0;
  logic [N*W-1:0] Req_Data = '0;
  logic [N-1:0]   Req_Ready;
  logic [W-1:0]   Output_Data;
  logic           Output_Valid;
  logic           Output_Ready = 1'b0;
  logic [1:0]     Grant_Id;

  bypass_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .Output_Data(Output_Data), .Output_Valid(Output_Valid),
    .Output_Ready(Output_Ready), .Grant_Id(Grant_Id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  gid;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [3:0] rv, input logic [31:0] d, input logic ordy,
                     input logic [3:0] rdy, input logic ov, input logic [7:0] od,
                     input logic [1:0] gid);
    vec_t v;
    v.rv = rv; v.d = d; v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.od = od; v.gid = gid;
    tv.push_back(v);
  endtask

  // reference model state
  logic       mov;
  logic [7:0] mdata;
  int         mid, mlast;

  function automatic logic [3:0] model_ready(input logic [3:0] rv, input logic ordy);
    logic load;
    load = !mov || ordy;
    for (int j = 1; j <= N; j++) begin
      int idx;
      idx = (mlast + j) % N;
      if (rv[idx]) return load ? 4'(1 << idx) : 4'b0;
    end
    return 4'b0;
  endfunction

  localparam logic [31:0] D_INC = 32'h13121110;
  localparam logic [31:0] D_5A  = 32'h135A1110;

  initial begin
    // fairness from reset: 0,1,2,3 twice
    for (int k = 0; k < 8; k++)
      add(4'hF, D_INC, 1'b1, 4'(1 << (k % 4)), 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4));
    add(4'b0100, D_5A,  1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2);   // single requester
    add(4'b0010, D_INC, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);   // fill with 0x11
    for (int k = 0; k < 5; k++)
      add(4'hF, D_INC, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);    // backpressure
    add(4'hF,    D_INC, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);   // next in order
    add(4'b1000, D_INC, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);   // pointer to 3
    add(4'b1001, D_INC, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);   // wrap to 0
    add(4'b1001, D_INC, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    add(4'b0000, D_INC, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3);   // drain, data held
    add(4'b0000, D_INC, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3);
    add(4'b0001, D_INC, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0);   // empty loads despite !ready
    add(4'b0001, D_INC, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0);   // full, stalled

    // T1: reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      Req_Valid = 4'($urandom) | 4'b0001;
      Req_Data = $urandom;
      Output_Ready = 1'($urandom);
      #1;
      chk("reset_ready", 32'(Req_Ready), 0);
      chk("reset_valid", 32'(Output_Valid), 0);
      chk("reset_data", 32'(Output_Data), 0);
      chk("reset_gid", 32'(Grant_Id), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      Req_Valid = tv[i].rv; Req_Data = tv[i].d; Output_Ready = tv[i].ordy;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(Req_Ready), 32'(tv[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(Output_Valid), 32'(tv[i].ov));
      chk($sformatf("vec%0d_data", i), 32'(Output_Data), 32'(tv[i].od));
      chk($sformatf("vec%0d_gid", i), 32'(Grant_Id), 32'(tv[i].gid));
      @(negedge clk);
    end

    // T6: asynchronous reset mid-cycle while FULL
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(Output_Valid), 0);
    chk("midrst_data", 32'(Output_Data), 0);
    chk("midrst_ready", 32'(Req_Ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    Req_Valid = 4'hF; Req_Data = D_INC; Output_Ready = 1'b1;
    #1;
    chk("postrst_ready", 32'(Req_Ready), 32'h1);
    @(posedge clk); #1;
    chk("postrst_gid", 32'(Grant_Id), 0);
    chk("postrst_data", 32'(Output_Data), 32'h10);

    // randomized traffic from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mov = 1'b0; mdata = 8'h00; mid = 0; mlast = N - 1;
    for (int k = 0; k < 400; k++) begin
      logic [3:0] er;
      @(negedge clk);
      Req_Valid = 4'($urandom);
      Req_Data = $urandom;
      Output_Ready = ($urandom_range(0, 3) != 0);
      #1;
      er = model_ready(Req_Valid, Output_Ready);
      chk("rand_ready", 32'(Req_Ready), 32'(er));
      @(posedge clk);
      if (er != 0) begin
        for (int i = 0; i < N; i++)
          if (er[i]) begin
            mov = 1'b1; mdata = Req_Data[i*W +: W]; mid = i; mlast = i;
          end
      end else if (Output_Ready) begin
        mov = 1'b0;
      end
      #1;
      chk("rand_valid", 32'(Output_Valid), 32'(mov));
      chk("rand_data", 32'(Output_Data), 32'(mdata));
      chk("rand_gid", 32'(Grant_Id), 32'(mid));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
